// File: rtl/mux_gate_pipe.sv
// Selects one of NUM_IN words, gates it with gate_i, and presents the result
// behind a valid/ready output stage backed by a single skid register.
module mux_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    gate_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]        out_sel_o
);

    logic [WIDTH-1:0] res;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             accept;
    logic             out_free;

    // Out-of-range selects match no word and therefore produce zero.
    always_comb begin
        res = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                res = data_i[k*WIDTH +: WIDTH];
            end
        end
        res = res & {WIDTH{gate_i}};
    end

    // Ready depends only on the skid register, so there is no
    // combinational path from out_ready_i back to the source.
    assign in_ready_o = ~skid_valid;
    assign accept     = in_valid_i & in_ready_o;
    assign out_free   = ~out_valid_o | out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sel_o   <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_sel    <= '0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_o <= 1'b1;
                out_data_o  <= skid_data;
                out_sel_o   <= skid_sel;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid_o <= 1'b1;
                out_data_o  <= res;
                out_sel_o   <= sel_i;
            end else begin
                out_valid_o <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= res;
            skid_sel   <= sel_i;
        end
    end

endmodule

// File: tb/tb_mux_gate_pipe.sv
// Directed and randomized checks of mux_gate_pipe against a two-deep FIFO
// reference model; a second NUM_IN=3 instance covers out-of-range selects.
module tb_mux_gate_pipe;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data = '0;
    logic [1:0]  sel = '0;
    logic        gate = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;

    logic        v3 = 1'b0;
    logic        in_ready3;
    logic [23:0] d3 = {8'hC3, 8'hB2, 8'hA1};
    logic [1:0]  s3 = '0;
    logic        g3 = 1'b1;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;

    int checks = 0;
    int errors = 0;

    item_t      q[$];
    logic [7:0] popped[$];
    logic [7:0] last_data = '0;
    logic [1:0] last_sel = '0;

    always #5 clk = ~clk;

    mux_gate_pipe #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data_i(data), .sel_i(sel), .gate_i(gate),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_sel_o(out_sel)
    );

    mux_gate_pipe #(.WIDTH(8), .NUM_IN(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(v3), .in_ready_o(in_ready3),
        .data_i(d3), .sel_i(s3), .gate_i(g3),
        .out_valid_o(out_valid3), .out_ready_i(1'b1),
        .out_data_o(out_data3), .out_sel_o(out_sel3)
    );

    function automatic logic [7:0] ref_res(logic [31:0] d, int s, logic g, int n);
        if (s >= n || !g) return 8'h00;
        return 8'((d >> (s * 8)) & 32'hFF);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // compare every output of the main instance a moment after the edge.
    task automatic cycle();
        bit    acc;
        bit    pop;
        item_t it;
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_data = '0;
            last_sel  = '0;
        end else begin
            acc     = in_valid && (q.size() < 2);
            pop     = (q.size() > 0) && out_ready;
            it.data = ref_res(data, int'(sel), gate, 4);
            it.sel  = sel;
            if (pop) begin
                popped.push_back(q[0].data);
                void'(q.pop_front());
            end
            if (acc) q.push_back(it);
            if (q.size() > 0) begin
                last_data = q[0].data;
                last_sel  = q[0].sel;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_data", 32'(out_data), 32'(last_data));
        chk("out_sel", 32'(out_sel), 32'(last_sel));
    endtask

    initial begin
        int valid_cycles;

        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        cycle();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single word, gate open
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        sel = 2'd2; gate = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("gate1_valid", 32'(out_valid), 32'd1);
        chk("gate1_data", 32'(out_data), 32'h33);
        chk("gate1_sel", 32'(out_sel), 32'd2);
        cycle();

        // single word, gate closed
        gate = 1'b0; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("gate0_valid", 32'(out_valid), 32'd1);
        chk("gate0_data", 32'(out_data), 32'h00);
        chk("gate0_sel", 32'(out_sel), 32'd2);
        cycle();
        chk("idle_hold_data", 32'(out_data), 32'h00);

        // out-of-range select on the three-input instance, then an in-range one
        s3 = 2'd3; v3 = 1'b1;
        @(posedge clk); #1;
        chk("n3_oor_valid", 32'(out_valid3), 32'd1);
        chk("n3_oor_data", 32'(out_data3), 32'h00);
        chk("n3_oor_sel", 32'(out_sel3), 32'd3);
        s3 = 2'd1;
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("n3_sel1_data", 32'(out_data3), 32'hB2);
        chk("n3_sel1_sel", 32'(out_sel3), 32'd1);

        // backpressure: three words, consumer stalls from the second cycle
        popped.delete();
        gate = 1'b1;
        sel = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        sel = 2'd1; out_ready = 1'b0;
        cycle();
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        sel = 2'd2;
        cycle();
        chk("bp_stall_data", 32'(out_data), 32'h11);
        cycle();
        chk("bp_stall_data2", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_pop_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("bp_order0", 32'(popped[0]), 32'h11);
            chk("bp_order1", 32'(popped[1]), 32'h22);
            chk("bp_order2", 32'(popped[2]), 32'h33);
        end

        // streaming: 16 back-to-back words with the consumer always ready
        valid_cycles = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data = $urandom(); sel = 2'($urandom_range(0, 3)); gate = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            cycle();
            if (out_valid) valid_cycles++;
        end
        in_valid = 1'b0;
        cycle();
        if (out_valid) valid_cycles++;
        chk("stream_valid_cycles", 32'(valid_cycles), 32'd16);
        chk("stream_drained", 32'(out_valid), 32'd0);

        // reset with both entries full
        data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3; gate = 1'b1;
        cycle();
        cycle();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        chk("full_rst_valid", 32'(out_valid), 32'd0);
        chk("full_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("full_rst_no_ghost", 32'(out_valid), 32'd0);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            data      = $urandom();
            sel       = 2'($urandom_range(0, 3));
            gate      = ($urandom_range(0, 4) != 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
